// File: rtl/rank_code_pkg.sv
// Shared definitions for the rank-order stream encoder and decoder:
// FSM state encoding, stream marker value and unranked-pixel sentinel.
package rank_code_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      CLEAR,
      COLLECT,
      DONE
   } state_t;

   // Marker is the all-ones code one bit above the pixel address range.
   function automatic int unsigned marker_of(input int unsigned size);
      return 2 * size - 1;
   endfunction

   // A pixel that has not been ranked yet holds IMAGE_SIZE.
   function automatic int unsigned rank_sentinel(input int unsigned size);
      return size;
   endfunction

endpackage

// File: rtl/rank_order_decoder_if.sv
// Index stream between the image sorter and the rank-order decoder.
// INDEX_IN/INDEX_VALID from the sorter, BUSY back-pressure from the decoder.
interface rank_order_decoder_if #(
   parameter int IW = 10
);
   logic [IW-1:0] INDEX_IN;
   logic          INDEX_VALID;
   logic          BUSY;

   modport master (
      output INDEX_IN,
      output INDEX_VALID,
      input  BUSY
   );

   modport slave (
      input  INDEX_IN,
      input  INDEX_VALID,
      output BUSY
   );
endinterface

// File: rtl/rank_map_regs.sv
// Per-pixel rank register array: one write port, full parallel read-out.
// Ports: i_clk, i_rst (sync), i_we/i_waddr/i_wdata write port, o_rank map.
module rank_map_regs
   import rank_code_pkg::*;
#(
   parameter int SIZE = 256,
   parameter int AW   = 8,
   parameter int DW   = 9
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rank [0:SIZE-1]
);

   localparam logic [DW-1:0] SENT = DW'(rank_sentinel(SIZE));

   logic [DW-1:0] r_map [0:SIZE-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < SIZE; k++) begin
            r_map[k] <= SENT;
         end
      end else if (i_we) begin
         r_map[i_waddr] <= i_wdata;
      end
   end

   assign o_rank = r_map;

endmodule

// File: rtl/rank_order_decoder.sv
// Rank-order decoder: AER preamble detect, rank map clear, index collect.
// Ports: CLK, RST (sync), idx stream slave, INFERENCE_DONE, RANK map,
// RANKS_RECEIVED, FRAME_DONE pulse, sticky ERR_DUP / ERR_RANGE.
module rank_order_decoder
   import rank_code_pkg::*;
#(
   parameter int IMAGE_SIZE      = 256,
   parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int PIXEL_MAX_VALUE = 255
) (
   input  logic                     CLK,
   input  logic                     RST,
   rank_order_decoder_if.slave      idx,
   input  logic                     INFERENCE_DONE,
   output logic [IMAGE_SIZE_BITS:0] RANK [0:IMAGE_SIZE-1],
   output logic [IMAGE_SIZE_BITS:0] RANKS_RECEIVED,
   output logic                     FRAME_DONE,
   output logic                     ERR_DUP,
   output logic                     ERR_RANGE
);

   localparam int AW = IMAGE_SIZE_BITS;
   localparam int RW = IMAGE_SIZE_BITS + 1;
   localparam int IW = IMAGE_SIZE_BITS + 2;

   localparam logic [IW-1:0] MARK   = IW'(marker_of(IMAGE_SIZE));
   localparam logic [IW-1:0] SIZE_I = IW'(IMAGE_SIZE);
   localparam logic [RW-1:0] SENT   = RW'(rank_sentinel(IMAGE_SIZE));
   localparam logic [RW-1:0] LASTC  = RW'(IMAGE_SIZE - 1);
   localparam logic [AW-1:0] LASTA  = AW'(IMAGE_SIZE - 1);

   if (PIXEL_MAX_VALUE < 1) begin : g_bad_pix
      $error("PIXEL_MAX_VALUE must be at least 1");
   end

   state_t        r_state;
   logic [1:0]    r_mcnt;
   logic [AW-1:0] r_clr_addr;
   logic [RW-1:0] r_cnt;
   logic          r_busy;
   logic          r_fd;
   logic          r_dup;
   logic          r_rng;

   logic          w_acc;
   logic          w_mark;
   logic          w_in_rng;
   logic [AW-1:0] w_addr;
   logic          w_dup;
   logic          w_store;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [RW-1:0] w_wdata;

   assign w_acc    = idx.INDEX_VALID && !r_busy;
   assign w_mark   = idx.INDEX_IN == MARK;
   assign w_in_rng = idx.INDEX_IN < SIZE_I;
   assign w_addr   = idx.INDEX_IN[AW-1:0];
   // Registered map value: a same-edge write is not yet visible here.
   assign w_dup    = w_in_rng && (RANK[w_addr] != SENT);
   assign w_store  = (r_state == COLLECT) && w_acc && w_in_rng && !w_dup;

   // Clear sequence and rank stores share the single write port.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_addr;
      w_wdata = SENT;
      if (r_state == CLEAR) begin
         w_we = 1'b1;
      end else if (w_store) begin
         w_we    = 1'b1;
         w_waddr = w_addr;
         w_wdata = r_cnt;
      end
   end

   rank_map_regs #(
      .SIZE (IMAGE_SIZE),
      .AW   (AW),
      .DW   (RW)
   ) u_map (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .o_rank  (RANK)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_mcnt     <= '0;
         r_clr_addr <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_fd       <= 1'b0;
         r_dup      <= 1'b0;
         r_rng      <= 1'b0;
      end else begin
         r_fd <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_acc && w_mark) begin
                  r_state <= SYNC;
                  r_mcnt  <= 2'd1;
               end
            end
            SYNC: begin
               if (w_acc) begin
                  if (w_mark && r_mcnt == 2'd1) begin
                     r_state    <= CLEAR;
                     r_mcnt     <= 2'd2;
                     r_busy     <= 1'b1;
                     r_clr_addr <= '0;
                     r_cnt      <= '0;
                     r_dup      <= 1'b0;
                     r_rng      <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_mcnt  <= '0;
                  end
               end
            end
            CLEAR: begin
               r_clr_addr <= r_clr_addr + AW'(1);
               if (r_clr_addr == LASTA) begin
                  r_state <= COLLECT;
                  r_mcnt  <= '0;
                  r_busy  <= 1'b0;
               end
            end
            COLLECT: begin
               if (w_acc && w_mark) begin
                  r_state <= SYNC;
                  r_mcnt  <= 2'd1;
               end else begin
                  if (w_acc && !w_in_rng) begin
                     r_rng <= 1'b1;
                  end else if (w_acc && w_dup) begin
                     r_dup <= 1'b1;
                  end
                  if (w_store) begin
                     r_cnt <= r_cnt + RW'(1);
                  end
                  if (INFERENCE_DONE ||
                      (w_store && r_cnt == LASTC)) begin
                     r_state <= DONE;
                     r_busy  <= 1'b1;
                     r_fd    <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign idx.BUSY       = r_busy;
   assign RANKS_RECEIVED = r_cnt;
   assign FRAME_DONE     = r_fd;
   assign ERR_DUP        = r_dup;
   assign ERR_RANGE      = r_rng;

endmodule
